turret_sequencer: RTL and testbench
===================================

# turret_sequencer

Sequences the pan/tilt turret from the tracker outputs. It consumes the centroid presence flag and latched coordinates, and drives the coordinate transform and servos through `driven_coordinates_x/y`. It decides when the target is locked and generates a timed fire pulse with cooldown. It runs on `CLOCK_50` between `tracking_buffer`/`coordinate_latch` and `Coordinate_transform_v2`.

## Interface
- `clock_frequency_mhz`, 50: clock rate; 1 ms = `clock_frequency_mhz*1000` cycles
- `LOCK_TOL`, 4: per-axis pixel tolerance for lock
- `SETTLE_MS`, 200: stable time required before firing
- `FIRE_MS`, 100: fire pulse length
- `COOLDOWN_MS`, 1000: dead time after firing
- `LOST_MS`, 500: hold time after target loss before homing
- `SCAN_STEP`, 8 / `SCAN_MS`, 20: sweep step and period (SCAN_TURRET_EN only)
- `clk` in 1: system clock (CLOCK_50)
- `rst_n` in 1: asynchronous, active-low reset
- `on_screen` in 1: target present
- `tracked_coordinates_x` in 10: target x, 0..639
- `tracked_coordinates_y` in 9: target y, 0..479
- `arm` in 1: firing permitted (level)
- `driven_coordinates_x` out 10: commanded x
- `driven_coordinates_y` out 9: commanded y
- `fire` out 1: trigger drive
- `state` out 3: current state encoding, for debug/LEDs

## Operation
- All outputs are registered. Reset values:
  - `driven` = (320, 240), the home position.
  - `fire` = 0.
  - `state` = IDLE.
- States: IDLE=0, TRACK=1, FIRE=2, COOLDOWN=3, LOST=4.
- **IDLE**
  - Driven holds home.
  - `on_screen`=1 → TRACK.
- **TRACK**
  - Driven ← tracked every cycle.
  - An anchor (x,y) is latched on entry. It is re-latched, and the lock timer cleared, whenever |tracked−anchor| > LOCK_TOL on either axis. Differences are computed as 11-bit signed values and then made absolute.
  - The lock timer counts ms ticks and saturates at SETTLE_MS.
  - `on_screen`=0 → LOST. This has priority over every other transition.
  - Else, if the timer equals SETTLE_MS and `arm`=1 → FIRE.
  - With `arm`=0, the timer stays saturated and FIRE is taken as soon as `arm` rises.
- **FIRE**
  - `fire`=1 and driven frozen.
  - After FIRE_MS → COOLDOWN.
  - Loss of `on_screen` does not abort the pulse.
  - `arm`=0 aborts: next cycle `fire`=0, state COOLDOWN.
- **COOLDOWN**
  - `fire`=0.
  - Driven ← tracked while `on_screen`=1, otherwise held.
  - After COOLDOWN_MS → TRACK if `on_screen` else LOST.
- **LOST**
  - Driven held.
  - `on_screen`=1 → TRACK.
  - After LOST_MS → IDLE, with driven set to home in the same transition.
- **Timebase:** ms ticks come from a prescaler that restarts on every state change and on every anchor re-latch. This makes all durations exact: N ms = N·clock_frequency_mhz·1000 cycles.
- **Reset mid-operation:** immediately forces reset values. A fire pulse in progress is cut.

## Timing
- Input to driven coordinates: 1 cycle latency in TRACK.
- State and `fire` change on the clock edge after the triggering condition.
- `fire` high duration = FIRE_MS·clock_frequency_mhz·1000 cycles exactly, unless aborted.
- Fire latency: first cycle of `fire` = TRACK entry (or last re-latch) + SETTLE_MS·clock_frequency_mhz·1000 + 1 cycles.
- Inputs are assumed synchronous to `clk`; `tracked_coordinates_*` are stable whenever `on_screen`=1.

## Configuration
- **`SCAN_TURRET_EN` defined:**
  - In IDLE, driven_x moves by SCAN_STEP every SCAN_MS, clamped to 0..639.
  - The direction reverses on reaching either bound.
  - driven_y = 240.
  - On entering IDLE from reset or LOST, the sweep starts from 320 moving up.
- **Not defined:** IDLE holds home. SCAN_STEP/SCAN_MS are unused.

## Structure
- **`turret_pkg`:**
  - State enum `turret_state_t`.
  - Constants SCREEN_W=640, SCREEN_H=480, HOME_X=320, HOME_Y=240.
- **Sub-module `ms_tick`:**
  - Prescaler with a synchronous `restart` input.
  - Emits a one-cycle `tick` every `clock_frequency_mhz*1000` cycles.
- The main FSM plus duration counters live in `turret_sequencer`.

## Test plan
Bench parameters: clock_frequency_mhz=1, LOCK_TOL=4, SETTLE_MS=2, FIRE_MS=1, COOLDOWN_MS=3, LOST_MS=2.

- **Reset:** assert rst_n=0 mid-FIRE → same cycle driven=(320,240), fire=0, state=0.
- **Lock and fire:** on_screen=1, target (100,50) steady, arm=1 → TRACK next cycle. `fire` rises 2001 cycles after TRACK entry and lasts exactly 1000 cycles. COOLDOWN lasts 3000 cycles, then back to TRACK.
- **Jitter:**
  - Target alternates (100,50)/(103,53) → lock still fires at 2001.
  - A single step to (106,50) at cycle 1500 re-latches the anchor, so fire is at 1500+2001.
- **Loss:**
  - on_screen drops in TRACK → LOST, driven held.
  - Returns at cycle 1500 → TRACK.
  - Otherwise IDLE at 2000 with driven=(320,240).
- **Abort and priority:**
  - arm falls during FIRE → fire=0 next cycle, state=3.
  - on_screen=0 on the cycle lock completes → LOST, fire stays 0.
- **SCAN_TURRET_EN:** idle with SCAN_STEP=8, SCAN_MS=1 → x = 320, 328, … up to 639, then reverses and steps down. y=240 throughout.

Source files
------------

// File: rtl/turret_pkg.sv
// Shared types and screen constants for the turret sequencer.
package turret_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRACK    = 3'd1,
        ST_FIRE     = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_LOST     = 3'd4
    } turret_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int HOME_X   = 320;
    localparam int HOME_Y   = 240;
    localparam int X_W      = $clog2(SCREEN_W);
    localparam int Y_W      = $clog2(SCREEN_H);

    // Absolute difference of two zero-extended coordinates in 11-bit two's complement.
    function automatic logic [10:0] abs_diff11(input logic [10:0] a, input logic [10:0] b);
        logic [10:0] d;
        d = a - b;
        return d[10] ? (11'd0 - d) : d;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/turret_sequencer_ms_tick.sv
// Millisecond prescaler: one-cycle tick every clock_frequency_mhz*1000 cycles,
// restartable so that durations measured in ticks are exact.
module ms_tick #(
    parameter int clock_frequency_mhz = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CYCLES = clock_frequency_mhz * 1000;
    localparam int CW     = $clog2(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Next prescaler count.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/turret_sequencer.sv
// Turret lock/fire sequencer. Define SCAN_TURRET_EN to sweep x while IDLE
// instead of holding the home position.
module turret_sequencer
    import turret_pkg::*;
#(
    parameter int clock_frequency_mhz = 50,
    parameter int LOCK_TOL            = 4,
    parameter int SETTLE_MS           = 200,
    parameter int FIRE_MS             = 100,
    parameter int COOLDOWN_MS         = 1000,
    parameter int LOST_MS             = 500,
    parameter int SCAN_STEP           = 8,
    parameter int SCAN_MS             = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       on_screen,
    input  logic [9:0] tracked_coordinates_x,
    input  logic [8:0] tracked_coordinates_y,
    input  logic       arm,
    output logic [9:0] driven_coordinates_x,
    output logic [8:0] driven_coordinates_y,
    output logic       fire,
    output logic [2:0] state
);

    localparam int TW = $clog2(max_int(max_int(max_int(SETTLE_MS, FIRE_MS),
                                max_int(COOLDOWN_MS, LOST_MS)), max_int(SCAN_MS, 2)) + 1);
    localparam logic [TW-1:0]  SETTLE_T = TW'(SETTLE_MS);
    localparam logic [TW-1:0]  FIRE_END = TW'(FIRE_MS - 1);
    localparam logic [TW-1:0]  COOL_END = TW'(COOLDOWN_MS - 1);
    localparam logic [TW-1:0]  LOST_END = TW'(LOST_MS - 1);
    localparam logic [10:0]    TOL      = 11'(LOCK_TOL);
    localparam logic [X_W-1:0] HOME_XV  = X_W'(HOME_X);
    localparam logic [Y_W-1:0] HOME_YV  = Y_W'(HOME_Y);

    turret_state_t  state_q, state_d;
    logic [X_W-1:0] drv_x_q, drv_x_d;
    logic [Y_W-1:0] drv_y_q, drv_y_d;
    logic [X_W-1:0] anchor_x_q, anchor_x_d;
    logic [Y_W-1:0] anchor_y_q, anchor_y_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           fire_q, fire_d;
    logic           tick_s;
    logic           relatch_s;
    logic           restart_s;
    logic           off_anchor_s;

    assign off_anchor_s = (abs_diff11({1'b0, tracked_coordinates_x}, {1'b0, anchor_x_q}) > TOL) ||
                          (abs_diff11({2'b00, tracked_coordinates_y}, {2'b00, anchor_y_q}) > TOL);

`ifdef SCAN_TURRET_EN
    localparam logic [TW-1:0]  SCAN_END = TW'(SCAN_MS - 1);
    localparam logic [X_W-1:0] X_MAX    = X_W'(SCREEN_W - 1);
    localparam logic [X_W-1:0] STEP_X   = X_W'(SCAN_STEP);
    logic        scan_up_q, scan_up_d;
    logic [10:0] scan_sum_s;
    assign scan_sum_s = {1'b0, drv_x_q} + 11'(SCAN_STEP);
`endif

    ms_tick #(
        .clock_frequency_mhz(clock_frequency_mhz)
    ) u_ms_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Next-state, commanded position, anchor and duration timer.
    always_comb begin
        state_d    = state_q;
        drv_x_d    = drv_x_q;
        drv_y_d    = drv_y_q;
        anchor_x_d = anchor_x_q;
        anchor_y_d = anchor_y_q;
        timer_d    = timer_q;
        relatch_s  = 1'b0;
`ifdef SCAN_TURRET_EN
        scan_up_d  = scan_up_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (on_screen) begin
                    state_d = ST_TRACK;
`ifdef SCAN_TURRET_EN
                end else if (tick_s && (timer_q == SCAN_END)) begin
                    drv_y_d = HOME_YV;
                    if (scan_up_q) begin
                        if (scan_sum_s >= {1'b0, X_MAX}) begin
                            drv_x_d   = X_MAX;
                            scan_up_d = 1'b0;
                        end else begin
                            drv_x_d = scan_sum_s[X_W-1:0];
                        end
                    end else begin
                        if (drv_x_q <= STEP_X) begin
                            drv_x_d   = '0;
                            scan_up_d = 1'b1;
                        end else begin
                            drv_x_d = drv_x_q - STEP_X;
                        end
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (!on_screen) begin
                    state_d = ST_LOST;
                end else begin
                    drv_x_d = tracked_coordinates_x;
                    drv_y_d = tracked_coordinates_y;
                    // A moved target restarts the settle window rather than firing.
                    if (off_anchor_s) begin
                        relatch_s = 1'b1;
                    end else if ((timer_q == SETTLE_T) && arm) begin
                        state_d = ST_FIRE;
                    end else begin
                        state_d = ST_TRACK;
                    end
                end
            end
            ST_FIRE: begin
                if (!arm) begin
                    state_d = ST_COOLDOWN;
                end else if (tick_s && (timer_q == FIRE_END)) begin
                    state_d = ST_COOLDOWN;
                end else begin
                    state_d = ST_FIRE;
                end
            end
            ST_COOLDOWN: begin
                if (on_screen) begin
                    drv_x_d = tracked_coordinates_x;
                    drv_y_d = tracked_coordinates_y;
                end else begin
                    drv_x_d = drv_x_q;
                end
                if (tick_s && (timer_q == COOL_END)) begin
                    state_d = on_screen ? ST_TRACK : ST_LOST;
                end else begin
                    state_d = ST_COOLDOWN;
                end
            end
            ST_LOST: begin
                if (on_screen) begin
                    state_d = ST_TRACK;
                end else if (tick_s && (timer_q == LOST_END)) begin
                    state_d = ST_IDLE;
                    drv_x_d = HOME_XV;
                    drv_y_d = HOME_YV;
`ifdef SCAN_TURRET_EN
                    scan_up_d = 1'b1;
`endif
                end else begin
                    state_d = ST_LOST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                drv_x_d = HOME_XV;
                drv_y_d = HOME_YV;
            end
        endcase

        if (((state_d == ST_TRACK) && (state_q != ST_TRACK)) || relatch_s) begin
            anchor_x_d = tracked_coordinates_x;
            anchor_y_d = tracked_coordinates_y;
        end else begin
            anchor_x_d = anchor_x_q;
        end

        restart_s = (state_d != state_q) || relatch_s;

        // Durations count whole ms ticks from the last restart.
        if (restart_s) begin
            timer_d = '0;
        end else if (tick_s) begin
            case (state_q)
                ST_TRACK: begin
                    if (timer_q < SETTLE_T) begin
                        timer_d = timer_q + TW'(1);
                    end else begin
                        timer_d = timer_q;
                    end
                end
`ifdef SCAN_TURRET_EN
                ST_IDLE: begin
                    if (timer_q == SCAN_END) begin
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
`endif
                ST_FIRE, ST_COOLDOWN, ST_LOST: begin
                    timer_d = timer_q + TW'(1);
                end
                default: begin
                    timer_d = timer_q;
                end
            endcase
        end else begin
            timer_d = timer_q;
        end

        fire_d = (state_d == ST_FIRE);
    end

    // State, outputs and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            drv_x_q    <= HOME_XV;
            drv_y_q    <= HOME_YV;
            anchor_x_q <= HOME_XV;
            anchor_y_q <= HOME_YV;
            timer_q    <= '0;
            fire_q     <= 1'b0;
`ifdef SCAN_TURRET_EN
            scan_up_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            drv_x_q    <= drv_x_d;
            drv_y_q    <= drv_y_d;
            anchor_x_q <= anchor_x_d;
            anchor_y_q <= anchor_y_d;
            timer_q    <= timer_d;
            fire_q     <= fire_d;
`ifdef SCAN_TURRET_EN
            scan_up_q  <= scan_up_d;
`endif
        end
    end

    assign driven_coordinates_x = drv_x_q;
    assign driven_coordinates_y = drv_y_q;
    assign fire                 = fire_q;
    assign state                = state_q;

endmodule

// File: tb/tb_turret_sequencer.sv
// Directed bench for turret_sequencer at 1 MHz (1000 cycles per ms).
module tb_turret_sequencer;

    logic       clk;
    logic       rst_n;
    logic       on_screen;
    logic [9:0] tx;
    logic [8:0] ty;
    logic       arm;
    logic [9:0] dx;
    logic [8:0] dy;
    logic       fire;
    logic [2:0] state;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n;

    turret_sequencer #(
        .clock_frequency_mhz(1),
        .LOCK_TOL(4),
        .SETTLE_MS(2),
        .FIRE_MS(1),
        .COOLDOWN_MS(3),
        .LOST_MS(2),
        .SCAN_STEP(8),
        .SCAN_MS(1)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .on_screen             (on_screen),
        .tracked_coordinates_x (tx),
        .tracked_coordinates_y (ty),
        .arm                   (arm),
        .driven_coordinates_x  (dx),
        .driven_coordinates_y  (dy),
        .fire                  (fire),
        .state                 (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    // Counts negedges until state (sel=0) or fire (sel=1) equals val, bounded by limit.
    task automatic wait_for(input int sel, input logic [2:0] val, input int limit, output int cnt);
        cnt = 0;
        while ((cnt < limit) && !((sel == 0) ? (state === val) : (fire === val[0]))) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        on_screen = 1'b0;
        arm       = 1'b0;
        tx        = 10'd0;
        ty        = 9'd0;
        step(3);
        rst_n = 1'b1;
        step(1);

        push("reset_state", 0);   check(state);
        push("reset_fire", 0);    check(fire);
        push("reset_x", 320);     check(dx);
        push("reset_y", 240);     check(dy);

`ifdef SCAN_TURRET_EN
        begin
            int ex;
            int up;
            int last;
            int gap;
            ex   = 320;
            up   = 1;
            last = 320;
            for (int k = 0; k < 45; k++) begin
                if (up == 1) ex = ex + 8; else ex = ex - 8;
                if (ex > 639) ex = 639;
                if (ex < 0) ex = 0;
                if (ex == 639) up = 0;
                if (ex == 0) up = 1;
                push("scan_x", ex);
                gap = 0;
                while ((gap < 1100) && (dx === 10'(last))) begin
                    @(negedge clk);
                    gap++;
                end
                check(dx);
                push("scan_y", 240);
                check(dy);
                if (k > 0) begin
                    push("scan_period", 1000);
                    check(gap);
                end
                last = dx;
            end
        end
`else
        // Lock and fire on a steady target.
        tx = 10'd100; ty = 9'd50; on_screen = 1'b1; arm = 1'b1;
        push("lock_enter", 1);          wait_for(0, 3'd1, 5, n);    check(n);
        push("lock_fire_latency", 2001); wait_for(1, 3'd1, 2100, n); check(n);
        push("fire_state", 2);          check(state);
        push("fire_len", 1000);         wait_for(1, 3'd0, 1100, n); check(n);
        push("cool_state", 3);          check(state);
        push("cool_len", 3000);         wait_for(0, 3'd1, 3100, n); check(n);
        push("track_x", 100);           check(dx);
        push("track_y", 50);            check(dy);

        // Loss with no return homes the turret.
        arm = 1'b0; on_screen = 1'b0;
        push("lost_enter", 1);          wait_for(0, 3'd4, 5, n);    check(n);
        push("lost_to_idle", 2000);     wait_for(0, 3'd0, 2100, n); check(n);
        push("home_x", 320);            check(dx);
        push("home_y", 240);            check(dy);

        // Loss with return at 1500 ms-cycles.
        tx = 10'd100; ty = 9'd50; on_screen = 1'b1;
        push("reacq_enter", 1);         wait_for(0, 3'd1, 5, n);    check(n);
        step(5);
        on_screen = 1'b0;
        push("drop_enter", 1);          wait_for(0, 3'd4, 5, n);    check(n);
        tx = 10'd300; ty = 9'd200;
        step(10);
        push("lost_hold_x", 100);       check(dx);
        push("lost_hold_y", 50);        check(dy);
        step(1489);
        on_screen = 1'b1;
        push("return_track", 1);        wait_for(0, 3'd1, 3, n);    check(n);
        step(1);
        push("latency_x", 300);         check(dx);
        push("latency_y", 200);         check(dy);

        // Alternating jitter within tolerance still locks on schedule.
        arm = 1'b1; tx = 10'd100; ty = 9'd50;
        step(1);
        n = 0;
        while ((fire !== 1'b1) && (n < 2100)) begin
            if ((n % 2) == 0) begin tx = 10'd103; ty = 9'd53; end
            else begin tx = 10'd100; ty = 9'd50; end
            @(negedge clk);
            n++;
        end
        push("jitter_fire", 2001);      check(n);

        // Disarm during the pulse aborts it.
        arm = 1'b0; tx = 10'd100; ty = 9'd50;
        step(1);
        push("abort_fire", 0);          check(fire);
        push("abort_state", 3);         check(state);
        push("abort_cool_len", 3000);   wait_for(0, 3'd1, 3100, n); check(n);

        // A single step beyond tolerance re-latches the anchor.
        arm = 1'b1;
        step(1499);
        tx = 10'd106;
        push("relatch_fire", 2002);     wait_for(1, 3'd1, 2100, n); check(n);
        push("relatch_fire_len", 1000); wait_for(1, 3'd0, 1100, n); check(n);
        on_screen = 1'b0;
        push("cool_to_lost", 3000);     wait_for(0, 3'd4, 3100, n); check(n);
        push("cool_hold_x", 106);       check(dx);

        // Loss on the cycle lock completes wins over firing.
        tx = 10'd100; ty = 9'd50; on_screen = 1'b1;
        push("prio_enter", 1);          wait_for(0, 3'd1, 5, n);    check(n);
        step(2000);
        on_screen = 1'b0;
        step(1);
        push("prio_state", 4);          check(state);
        push("prio_fire", 0);           check(fire);

        // Asynchronous reset during a pulse.
        on_screen = 1'b1;
        push("rst_enter", 1);           wait_for(0, 3'd1, 5, n);    check(n);
        push("rst_fire_latency", 2001); wait_for(1, 3'd1, 2100, n); check(n);
        step(100);
        #2 rst_n = 1'b0;
        #1;
        push("midrst_fire", 0);         check(fire);
        push("midrst_state", 0);        check(state);
        push("midrst_x", 320);          check(dx);
        push("midrst_y", 240);          check(dy);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
